// File: rtl/palette_pkg.sv
// Shared types and constants for the multi-palette colour lookup.
package palette_pkg;

  localparam int unsigned COLOR_W     = 24;
  localparam int unsigned TRANSP_IDX  = 0;
  localparam int unsigned FLASH_CNT_W = 8;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } pal_state_t;

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette storage: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module palette_ram #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned WORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Both updates are non-blocking, so the read always sees pre-write data.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// Runtime-writable multi-palette colour lookup with per-palette hit-flash blink.
// Two-cycle read pipeline: RAM read in stage 1, transparency/flash mux in stage 2.
module palette_lut
  import palette_pkg::*;
#(
  parameter int unsigned          NUM_PAL      = 4,
  parameter int unsigned          IDX_W        = 4,
  parameter int unsigned          COLOR_W      = palette_pkg::COLOR_W,
  parameter int unsigned          TRANSP_IDX   = palette_pkg::TRANSP_IDX,
  parameter int unsigned          FLASH_FRAMES = 8,
  parameter logic [COLOR_W-1:0]   FLASH_COLOR  = 24'hFFFFFF,
  localparam int unsigned         PAL_W        = $clog2(NUM_PAL)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_start,
  input  logic               i_wr_en,
  input  logic [PAL_W-1:0]   i_wr_pal,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [COLOR_W-1:0] i_wr_color,
  input  logic               i_rd_valid,
  input  logic [PAL_W-1:0]   i_rd_pal,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic               i_flash_trig,
  input  logic [PAL_W-1:0]   i_flash_pal,
  output logic               o_ready,
  output logic               o_valid,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_transp
);

  localparam int unsigned DEPTH   = 2 ** IDX_W;
  localparam int unsigned ADDR_W  = PAL_W + IDX_W;
  localparam int unsigned ENTRIES = NUM_PAL * DEPTH;

  pal_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic                ready_q, ready_d;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [COLOR_W-1:0]  ram_wdata;
  logic                ram_re;
  logic [COLOR_W-1:0]  ram_rdata;

  logic [FLASH_CNT_W-1:0] flash_q [NUM_PAL];
  logic [FLASH_CNT_W-1:0] flash_d [NUM_PAL];

  logic                s1_valid_q;
  logic [PAL_W-1:0]    s1_pal_q;
  logic [IDX_W-1:0]    s1_idx_q;

  logic                valid_q;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                transp_q, transp_d;
  logic                flash_on;

  // Init/ready FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_INIT;
      clr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
    end
  end

  // Next state; also owns the RAM write port (clear sweep vs. user writes).
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    ready_d   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = clr_q;
    ram_wdata = '0;
    case (state_q)
      S_INIT: begin
        ram_we = 1'b1;
        if (clr_q == ADDR_W'(ENTRIES - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
      S_READY: begin
        ready_d   = 1'b1;
        ram_we    = i_wr_en;
        ram_waddr = {i_wr_pal, i_wr_idx};
        ram_wdata = i_wr_color;
      end
      default: begin
        state_d = S_INIT;
        clr_d   = '0;
      end
    endcase
  end

  assign ram_re = i_rd_valid & ready_q;

  palette_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i ({i_rd_pal, i_rd_idx}),
    .rdata_o (ram_rdata)
  );

  // Flash counters: a trigger load beats a same-cycle frame decrement.
  always_comb begin
    for (int p = 0; p < NUM_PAL; p++) begin
      flash_d[p] = flash_q[p];
      if (ready_q && i_flash_trig && (i_flash_pal == PAL_W'(p))) begin
        flash_d[p] = FLASH_CNT_W'(FLASH_FRAMES);
      end else if (i_frame_start && (flash_q[p] != '0)) begin
        flash_d[p] = flash_q[p] - FLASH_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        flash_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PAL; p++) begin
        flash_q[p] <= flash_d[p];
      end
    end
  end

  // Stage 1 sideband travelling alongside the RAM read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_pal_q   <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= ram_re;
      if (ram_re) begin
        s1_pal_q <= i_rd_pal;
        s1_idx_q <= i_rd_idx;
      end
    end
  end

  // Stage 2 colour selection.
  always_comb begin
    flash_on = (flash_q[s1_pal_q] != '0) && flash_q[s1_pal_q][0];
    transp_d = (s1_idx_q == IDX_W'(TRANSP_IDX));
    color_d  = ram_rdata;
    if (transp_d) begin
      color_d = '0;
    end else if (flash_on) begin
      color_d = FLASH_COLOR;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      color_q  <= '0;
      transp_q <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        color_q  <= color_d;
        transp_q <= transp_d;
      end
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_color  = color_q;
  assign o_transp = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_palette_lut;

  localparam int unsigned NPAL  = 4;
  localparam int unsigned NIDX  = 16;
  localparam logic [23:0] FLASH = 24'hFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_frame_start;
  logic        i_wr_en;
  logic [1:0]  i_wr_pal;
  logic [3:0]  i_wr_idx;
  logic [23:0] i_wr_color;
  logic        i_rd_valid;
  logic [1:0]  i_rd_pal;
  logic [3:0]  i_rd_idx;
  logic        i_flash_trig;
  logic [1:0]  i_flash_pal;
  logic        o_ready;
  logic        o_valid;
  logic [23:0] o_color;
  logic        o_transp;

  palette_lut dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_wr_en       (i_wr_en),
    .i_wr_pal      (i_wr_pal),
    .i_wr_idx      (i_wr_idx),
    .i_wr_color    (i_wr_color),
    .i_rd_valid    (i_rd_valid),
    .i_rd_pal      (i_rd_pal),
    .i_rd_idx      (i_rd_idx),
    .i_flash_trig  (i_flash_trig),
    .i_flash_pal   (i_flash_pal),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_color       (o_color),
    .o_transp      (o_transp)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: palette contents, flash counters, one in-flight lookup.
  logic [23:0] m_mem [NPAL][NIDX];
  int          m_cnt [NPAL];
  bit          m_ready;
  int          m_init_edges;
  bit          p_valid;
  int          p_pal, p_idx;
  logic [23:0] p_data;
  bit          e_valid;
  logic [23:0] e_color;
  bit          e_transp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NPAL; p++) begin
      m_cnt[p] = 0;
      for (int i = 0; i < NIDX; i++) m_mem[p][i] = '0;
    end
    m_ready = 0; m_init_edges = 0;
    p_valid = 0; e_valid = 0; e_color = '0; e_transp = 0;
  endtask

  // One clock edge of the model, using the inputs as sampled at that edge.
  task automatic model_edge();
    bit on;
    e_valid = p_valid;
    if (p_valid) begin
      on       = (m_cnt[p_pal] != 0) && (m_cnt[p_pal] % 2 == 1);
      e_transp = (p_idx == 0);
      e_color  = e_transp ? 24'h0 : (on ? FLASH : p_data);
    end
    p_valid = i_rd_valid && m_ready;
    if (p_valid) begin
      p_pal  = int'(i_rd_pal);
      p_idx  = int'(i_rd_idx);
      p_data = m_mem[p_pal][p_idx];
    end
    if (m_ready && i_wr_en) m_mem[i_wr_pal][i_wr_idx] = i_wr_color;
    for (int p = 0; p < NPAL; p++) begin
      if (m_ready && i_flash_trig && int'(i_flash_pal) == p) m_cnt[p] = 8;
      else if (i_frame_start && m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
    end
    if (!m_ready) begin
      m_init_edges++;
      if (m_init_edges == NPAL * NIDX) m_ready = 1;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("ready",  32'(o_ready),  32'(m_ready));
    chk("valid",  32'(o_valid),  32'(e_valid));
    chk("color",  32'(o_color),  32'(e_color));
    chk("transp", 32'(o_transp), 32'(e_transp));
  endtask

  task automatic idle();
    i_frame_start = 0; i_wr_en = 0; i_rd_valid = 0; i_flash_trig = 0;
  endtask

  task automatic set_wr(input int pal, input int idx, input logic [23:0] c);
    i_wr_en = 1; i_wr_pal = 2'(pal); i_wr_idx = 4'(idx); i_wr_color = c;
  endtask

  task automatic set_rd(input int pal, input int idx);
    i_rd_valid = 1; i_rd_pal = 2'(pal); i_rd_idx = 4'(idx);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("init_cycles", 32'(n), 32'(NPAL * NIDX));
  endtask

  // Read (1,3) two cycles after issue.
  task automatic read13(output logic [23:0] c);
    set_rd(1, 3); tick(); idle(); tick();
    c = o_color;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] c;
    int nv;
    idle();
    i_wr_pal = '0; i_wr_idx = '0; i_wr_color = '0;
    i_rd_pal = '0; i_rd_idx = '0; i_flash_pal = '0;
    i_rst = 1;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_color", 32'(o_color), 0);
    i_rst = 0;
    wait_ready();

    // Cleared entry, non-transparent index.
    set_rd(2, 5); tick(); idle(); tick();
    chk("t1_valid", 32'(o_valid), 1);
    chk("t1_color", 32'(o_color), 0);
    chk("t1_transp", 32'(o_transp), 0);

    // Write then read back.
    set_wr(1, 3, 24'h77d9d5); tick(); idle();
    read13(c);
    chk("t2_color", 32'(c), 32'h77d9d5);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      set_rd(1, i); tick(); nv += int'(o_valid);
    end
    idle();
    repeat (2) begin tick(); nv += int'(o_valid); end
    chk("t2_b2b_count", 32'(nv), 16);

    // Transparent index hides stored colour.
    set_wr(0, 0, 24'hedffff); tick(); idle();
    set_rd(0, 0); tick(); idle(); tick();
    chk("t3_transp", 32'(o_transp), 1);
    chk("t3_color", 32'(o_color), 0);

    // Read-before-write collision.
    set_wr(2, 7, 24'h01fefe); set_rd(2, 7); tick(); idle();
    set_rd(2, 7); tick(); idle();
    chk("t4_old", 32'(o_color), 0);
    tick();
    chk("t4_new", 32'(o_color), 32'h01fefe);

    // Flash blink over 10 frames.
    i_flash_trig = 1; i_flash_pal = 2'd1; tick(); idle();
    for (int f = 1; f <= 10; f++) begin
      int left;
      i_frame_start = 1; tick(); idle();
      read13(c);
      left = (f >= 8) ? 0 : 8 - f;
      chk($sformatf("t5_frame%0d", f), 32'(c), (left % 2 == 1) ? 32'(FLASH) : 32'h77d9d5);
    end
    // Retrigger at counter 3 reloads to 8.
    i_flash_trig = 1; tick(); idle();
    repeat (5) begin i_frame_start = 1; tick(); idle(); end
    read13(c);
    chk("t5_cnt3", 32'(c), 32'(FLASH));
    i_flash_trig = 1; tick(); idle();
    read13(c);
    chk("t5_reload", 32'(c), 32'h77d9d5);
    // Trigger together with frame_start: load wins (8, off) rather than 7 (on).
    i_flash_trig = 1; i_frame_start = 1; tick(); idle();
    read13(c);
    chk("t5_load_wins", 32'(c), 32'h77d9d5);
    i_frame_start = 1; tick(); idle();
    read13(c);
    chk("t5_after", 32'(c), 32'(FLASH));

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      i_wr_en       = ($urandom_range(0, 99) < 30);
      i_wr_pal      = 2'($urandom); i_wr_idx = 4'($urandom);
      i_wr_color    = 24'($urandom);
      i_rd_valid    = ($urandom_range(0, 99) < 60);
      i_rd_pal      = 2'($urandom); i_rd_idx = 4'($urandom);
      i_flash_trig  = ($urandom_range(0, 99) < 5);
      i_flash_pal   = 2'($urandom);
      i_frame_start = ($urandom_range(0, 99) < 10);
      tick();
    end

    // Reset with reads in flight.
    set_rd(3, 9); tick(); set_rd(3, 10); tick();
    i_rst = 1;
    #1;
    chk("t6_valid", 32'(o_valid), 0);
    chk("t6_ready", 32'(o_ready), 0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
    idle();
    wait_ready();
    for (int a = 0; a < NPAL * NIDX; a++) begin
      set_rd(a / NIDX, a % NIDX); tick();
    end
    idle();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
